decoder2to4_seq: RTL and testbench
==================================

Name: decoder2to4_seq

Overview:
- Registered 2-to-4 decoder with input buffering and timed one-hot output pulses.
- Counterpart of the 4-to-2 priority encoder: accepts 2-bit codes over a valid/ready handshake and queues them in a small FIFO.
- Replays each code as a one-hot strobe of programmable width, followed by a programmable idle gap.
- Drives downstream one-hot select/strobe lines, for example to reconstruct the encoder's input pattern.

Parameters:
- PULSE_LEN, 3: cycles each one-hot output stays asserted; must be >= 1.
- GAP_LEN, 1: cycles of out=0000 after each pulse; must be >= 0.
- DEPTH, 2: input FIFO entries; power of two, >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  FIFO can accept a code.
- in_code  input  2  binary code to decode.
- out  output  4  one-hot decoded strobe, out[in_code]=1 during a pulse.
- out_valid  output  1  high exactly while out is non-zero.
- out_code  output  2  code currently being emitted; holds its last value otherwise.
- busy  output  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (clk edge with rst=1):
  - out=0000, out_valid=0, out_code=00, busy=0.
  - FIFO flushed, FSM=IDLE, counter=0.
  - in_ready=0 while rst=1.
- in_ready = !rst && (fifo_count < DEPTH), combinational from registered count. A pop in the same cycle does not raise in_ready.
- Push: at an edge with in_valid && in_ready, in_code is written to the FIFO tail. in_valid with in_ready=0 is ignored; the code is dropped and never emitted.
- Latency: a code accepted at edge N into an empty FIFO, with FSM in IDLE, drives out from edge N+1. It holds for PULSE_LEN cycles, then out=0000 for GAP_LEN cycles.
- FSM states IDLE, PULSE, GAP:
  - IDLE: if FIFO non-empty at the edge, pop the head. Set out=1<<code, out_code=code, out_valid=1, cnt=PULSE_LEN-1. Go to PULSE.
  - PULSE: if cnt!=0, decrement.
    - At cnt==0 with GAP_LEN>0: out=0000, out_valid=0, cnt=GAP_LEN-1, go to GAP.
    - At cnt==0 with GAP_LEN==0: if FIFO non-empty, pop and reload (stay in PULSE, contiguous pulses); else out=0000 and go to IDLE.
  - GAP: if cnt!=0, decrement.
    - At cnt==0: if FIFO non-empty, pop and load PULSE directly (no IDLE bubble); else go to IDLE.
  - Result: back-to-back codes produce pulse starts exactly PULSE_LEN+GAP_LEN cycles apart.
- Simultaneous push and pop on the same edge is legal when not full; count is unchanged.
- The pointer width is clog2(DEPTH) and wraps modulo DEPTH. The count width is clog2(DEPTH+1).
- Counter width is clog2(max(PULSE_LEN,GAP_LEN,2)).
- busy = (state!=IDLE) || (fifo_count!=0).
- Reset mid-pulse or mid-gap: outputs return to reset values at that edge and queued codes are discarded.
- out is always 0000 or exactly one bit set; never multi-hot.

Decomposition:
- Shared package dec_pkg holds:
  - CODE_W=2 and ONEHOT_W=4.
  - State enum {IDLE, PULSE, GAP}.
  - Function onehot(code) returning 1<<code.
- One sub-module, code_fifo: a synchronous DEPTH x CODE_W FIFO with push/pop/full/empty/count and synchronous active-high rst.
- Top level holds the FSM, counter and output registers.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid=1, in_code=11. Expect out=0000, out_valid=0, busy=0, in_ready=0 during reset and in_ready=1 the cycle after release; nothing is emitted.
- Single code: in_code=10 accepted at edge N (defaults). Expect out=0100, out_code=10 for edges N+1..N+3, then out=0000 at N+4, and busy=0 from N+5.
- Stream: with in_valid held, present 00, 01, 10, 11 each advanced on handshake. Expect out = 0001, 0010, 0100, 1000, each 3 cycles with 1-cycle 0000 gaps, pulse starts 4 cycles apart, and in_ready low while 2 codes are queued.
- Overflow: fill the FIFO during a pulse, then drive in_code=11 with in_ready=0. Expect code 11 never to appear on out.
- Reset mid-operation: assert rst during the 2nd cycle of a pulse with 2 queued codes. Expect out=0000 next cycle and no further pulses after release.
- GAP_LEN=0, PULSE_LEN=1: send 01, 11 back-to-back. Expect out=0010 then 1000 on consecutive cycles with out_valid continuously high.

Source files
------------

// File: rtl/decoder2to4_seq_pkg.sv
// Shared widths, FSM state type and the code-to-one-hot helper for the
// registered 2-to-4 decoder.
package dec_pkg;

  localparam int CODE_W   = 2;
  localparam int ONEHOT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // One-hot strobe with bit [code] set.
  function automatic logic [ONEHOT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [ONEHOT_W-1:0] one;
    one = {{(ONEHOT_W-1){1'b0}}, 1'b1};
    return one << code;
  endfunction

endpackage

// File: rtl/decoder2to4_seq_if.sv
// Bus bundle for the decoder: code input handshake plus decoded strobe outputs.
//
// Handshake: a code transfers on a rising clk edge where in_valid and in_ready
// are both high. The producer may change in_code/in_valid freely; a code
// presented while in_ready is low is not taken and is simply lost. in_ready
// depends only on reset and registered FIFO occupancy, never on in_valid.
interface decoder2to4_seq_if;
  import dec_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [CODE_W-1:0]   in_code;
  logic [ONEHOT_W-1:0] out;
  logic                out_valid;
  logic [CODE_W-1:0]   out_code;
  logic                busy;

  modport master (
    output in_valid, in_code,
    input  in_ready, out, out_valid, out_code, busy
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, out, out_valid, out_code, busy
  );

endinterface

// File: rtl/decoder2to4_seq_code_fifo.sv
// Small synchronous FIFO holding pending 2-bit codes. Pointers wrap modulo
// DEPTH explicitly so non-power-of-two sizes would still behave.
module code_fifo
  import dec_pkg::*;
#(
  parameter int  DEPTH  = 2,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int FCNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [FCNT_W-1:0] count
);

  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(DEPTH);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping, flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decoder2to4_seq.sv
// Registered 2-to-4 decoder: buffers incoming codes and replays each as a
// PULSE_LEN-cycle one-hot strobe followed by GAP_LEN idle cycles.
module decoder2to4_seq
  import dec_pkg::*;
#(
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 1,
  parameter int DEPTH     = 2
) (
  input  logic              clk,
  input  logic              rst,
  decoder2to4_seq_if.slave  bus,
  output state_e            fsm_state
);

  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? ((PULSE_LEN > 2) ? PULSE_LEN : 2)
                                                 : ((GAP_LEN > 2) ? GAP_LEN : 2);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int FCNT_W  = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ONEHOT_W-1:0] out_q, out_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;

  logic                push;
  logic                pop;
  logic [CODE_W-1:0]   head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FCNT_W-1:0]   fifo_count;

  assign bus.in_ready = !rst && !fifo_full;
  assign push         = bus.in_valid && bus.in_ready;

  code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_code),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state and output decode: pop a queued code whenever the previous
  // pulse/gap window has fully elapsed, so starts are PULSE_LEN+GAP_LEN apart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    code_d  = code_q;
    valid_d = valid_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          out_d   = onehot(head);
          code_d  = head;
          valid_d = 1'b1;
          cnt_d   = PULSE_RELOAD;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_LEN > 0) begin
          out_d   = '0;
          valid_d = 1'b0;
          cnt_d   = GAP_RELOAD;
          state_d = GAP;
        end else if (!fifo_empty) begin
          // Zero gap: chain the next code with no dead cycle.
          pop     = 1'b1;
          out_d   = onehot(head);
          code_d  = head;
          valid_d = 1'b1;
          cnt_d   = PULSE_RELOAD;
        end else begin
          out_d   = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          out_d   = onehot(head);
          code_d  = head;
          valid_d = 1'b1;
          cnt_d   = PULSE_RELOAD;
          state_d = PULSE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        out_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers; reset discards any pulse in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.out_code  = code_q;
  assign bus.busy      = (state_q != IDLE) || (fifo_count != '0);
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_decoder2to4_seq.sv
// Bench for decoder2to4_seq: two instances (default timing, and 1-cycle pulses
// with no gap) driven by directed steps then random traffic, checked every
// cycle against a schedule model: each accepted code starts at
// max(accept_edge+1, previous_start+PULSE_LEN+GAP_LEN).
module tb_decoder2to4_seq;
  import dec_pkg::*;

  localparam int MAXN = 2048;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder2to4_seq_if bus_a ();
  decoder2to4_seq_if bus_b ();
  state_e st_a, st_b;

  decoder2to4_seq #(.PULSE_LEN(3), .GAP_LEN(1), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .fsm_state(st_a)
  );
  decoder2to4_seq #(.PULSE_LEN(1), .GAP_LEN(0), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .fsm_state(st_b)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int now_t  = 0;
  int m_p [2];
  int m_g [2];
  int m_d [2];
  int m_n [2];
  int m_start [2][MAXN];
  logic [1:0] m_code [2][MAXN];
  logic drv_v [2];
  logic [1:0] drv_c [2];
  logic acc_last [2];
  logic [3:0] seen [2];
  int pulses [2];
  logic prev_v [2];
  logic [3:0] single_out_tab [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
  logic       single_busy_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  // ---------------- reference model ----------------
  function automatic int mdl_count(int i, int t);
    int c = 0;
    for (int k = 0; k < m_n[i]; k++) if (m_start[i][k] > t) c++;
    return c;
  endfunction

  function automatic logic mdl_ready(int i, int t, logic r);
    return !r && (mdl_count(i, t) < m_d[i]);
  endfunction

  function automatic logic [3:0] mdl_out(int i, int t);
    logic [3:0] o = 4'b0000;
    for (int k = 0; k < m_n[i]; k++)
      if (m_start[i][k] <= t && t < m_start[i][k] + m_p[i]) o = 4'(1 << m_code[i][k]);
    return o;
  endfunction

  function automatic logic [1:0] mdl_code(int i, int t);
    logic [1:0] c = 2'b00;
    for (int k = 0; k < m_n[i]; k++) if (m_start[i][k] <= t) c = m_code[i][k];
    return c;
  endfunction

  function automatic logic mdl_busy(int i, int t);
    logic b = (mdl_count(i, t) != 0);
    for (int k = 0; k < m_n[i]; k++)
      if (m_start[i][k] <= t && t < m_start[i][k] + m_p[i] + m_g[i]) b = 1'b1;
    return b;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d t=%0d observed=%0h expected=%0h", tag, i, now_t, obs, exp);
    end
  endtask

  task automatic check_outputs(input int i, input logic [3:0] o, input logic ov,
                               input logic [1:0] oc, input logic b);
    logic [3:0] e_out;
    e_out = mdl_out(i, now_t);
    chk("out", i, 8'(o), 8'(e_out));
    chk("out_valid", i, 8'(ov), 8'(e_out != 4'b0000));
    chk("out_code", i, 8'(oc), 8'(mdl_code(i, now_t)));
    chk("busy", i, 8'(b), 8'(mdl_busy(i, now_t)));
    chk("onehot0", i, 8'($onehot0(o)), 8'd1);
    seen[i] = seen[i] | o;
    if (ov === 1'b1 && prev_v[i] !== 1'b1) pulses[i]++;
    prev_v[i] = ov;
  endtask

  // ---------------- driver ----------------
  // One clock: drive inputs, check in_ready, take the edge, update model, check outputs.
  task automatic cycle();
    logic acc [2];
    bus_a.in_valid = drv_v[0];
    bus_a.in_code  = drv_c[0];
    bus_b.in_valid = drv_v[1];
    bus_b.in_code  = drv_c[1];
    for (int i = 0; i < 2; i++) acc[i] = drv_v[i] && mdl_ready(i, now_t, rst);
    #1;
    chk("in_ready", 0, 8'(bus_a.in_ready), 8'(mdl_ready(0, now_t, rst)));
    chk("in_ready", 1, 8'(bus_b.in_ready), 8'(mdl_ready(1, now_t, rst)));
    @(posedge clk);
    now_t++;
    for (int i = 0; i < 2; i++) begin
      acc_last[i] = acc[i];
      if (rst) begin
        m_n[i] = 0;
      end else if (acc[i] && m_n[i] < MAXN) begin
        int s;
        s = now_t + 1;
        if (m_n[i] > 0 && m_start[i][m_n[i]-1] + m_p[i] + m_g[i] > s)
          s = m_start[i][m_n[i]-1] + m_p[i] + m_g[i];
        m_start[i][m_n[i]] = s;
        m_code[i][m_n[i]]  = drv_c[i];
        m_n[i]++;
      end
    end
    #1;
    check_outputs(0, bus_a.out, bus_a.out_valid, bus_a.out_code, bus_a.busy);
    check_outputs(1, bus_b.out, bus_b.out_valid, bus_b.out_code, bus_b.busy);
  endtask

  // Present a code on instance i with valid held until it is taken.
  task automatic send(input int i, input logic [1:0] code);
    drv_v[i] = 1'b1;
    drv_c[i] = code;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (acc_last[i]) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout dut%0d code=%0d not accepted within 20 cycles", i, code);
  endtask

  // Idle until both instances have nothing pending or in flight.
  task automatic drain();
    drv_v[0] = 1'b0;
    drv_v[1] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!mdl_busy(0, now_t) && !mdl_busy(1, now_t)) return;
      cycle();
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout t=%0d model still busy after 60 cycles", now_t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0d simulation did not complete", now_t);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    m_p[0] = 3; m_g[0] = 1; m_d[0] = 2;
    m_p[1] = 1; m_g[1] = 0; m_d[1] = 2;
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; seen[i] = 4'b0000; pulses[i] = 0; prev_v[i] = 1'b0; acc_last[i] = 1'b0;
    end

    // Reset held two cycles with a code offered.
    rst = 1'b1;
    drv_v[0] = 1'b1; drv_c[0] = 2'b11;
    drv_v[1] = 1'b1; drv_c[1] = 2'b11;
    cycle();
    cycle();
    chk("rst_out", 0, 8'(bus_a.out), 8'h00);
    chk("rst_busy", 0, 8'(bus_a.busy), 8'h00);
    rst = 1'b0;
    drv_v[0] = 1'b0;
    drv_v[1] = 1'b0;
    cycle();
    chk("ready_after_rst", 0, 8'(bus_a.in_ready), 8'h01);
    chk("nothing_emitted", 0, 8'(seen[0]), 8'h00);

    // Single code 10 on the default instance.
    drv_v[0] = 1'b1; drv_c[0] = 2'b10;
    cycle();
    drv_v[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("single_out", 0, 8'(bus_a.out), 8'(single_out_tab[k]));
      chk("single_busy", 0, 8'(bus_a.busy), 8'(single_busy_tab[k]));
    end

    // Stream 00..11 with valid held.
    for (int c = 0; c < 4; c++) send(0, 2'(c));
    drain();
    chk("stream_all_codes", 0, 8'(seen[0]), 8'h0f);

    // Overflow: fill during a pulse, then offer 11 only while not ready.
    seen[0] = 4'b0000;
    send(0, 2'b00);
    send(0, 2'b01);
    send(0, 2'b10);
    for (int k = 0; k < 8; k++) begin
      drv_v[0] = !mdl_ready(0, now_t, 1'b0);
      drv_c[0] = 2'b11;
      cycle();
    end
    drain();
    chk("overflow_dropped", 0, 8'(seen[0][3]), 8'h00);
    chk("overflow_emitted", 0, 8'(seen[0]), 8'h07);

    // Reset in the second cycle of a pulse with two codes queued.
    send(0, 2'b00);
    send(0, 2'b01);
    send(0, 2'b10);
    drv_v[0] = 1'b0;
    rst = 1'b1;
    cycle();
    chk("midrst_out", 0, 8'(bus_a.out), 8'h00);
    rst = 1'b0;
    pulses[0] = 0;
    for (int k = 0; k < 10; k++) cycle();
    chk("midrst_no_pulse", 0, 8'(pulses[0]), 8'h00);

    // Zero-gap instance: 01 then 11 back to back.
    drv_v[1] = 1'b1; drv_c[1] = 2'b01;
    cycle();
    drv_c[1] = 2'b11;
    cycle();
    chk("b2b_first", 1, 8'(bus_b.out), 8'h02);
    chk("b2b_first_v", 1, 8'(bus_b.out_valid), 8'h01);
    drv_v[1] = 1'b0;
    cycle();
    chk("b2b_second", 1, 8'(bus_b.out), 8'h08);
    chk("b2b_second_v", 1, 8'(bus_b.out_valid), 8'h01);
    cycle();
    chk("b2b_end", 1, 8'(bus_b.out), 8'h00);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 2; i++) begin
        drv_v[i] = ($urandom_range(0, 2) != 0);
        drv_c[i] = 2'($urandom_range(0, 3));
      end
      cycle();
    end
    rst = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
